// File: rtl/ddr_pkg.sv
// ddr_pkg: app commands, beat address step, burst FSM states and default widths
package ddr_pkg;
  localparam logic [2:0] CMD_RD = 3'b000;
  localparam logic [2:0] CMD_WR = 3'b001;
  localparam int ADDR_STEP = 8;
  localparam int DEF_ADDR_W = 28;
  localparam int DEF_DATA_W = 512;
  localparam int DEF_LEN_W = 16;
  localparam int DEF_MAX_OUTSTANDING = 4;
  typedef enum logic [2:0] {IDLE, WR, RD, DRAIN, DONE} state_e;
endpackage

// File: rtl/ddr_cmd_slot.sv
// ddr_cmd_slot: one-entry app command/write-data holding register, stable until accepted
module ddr_cmd_slot import ddr_pkg::*; #(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [2:0]        ld_cmd,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              app_rdy,
  input  logic              app_wdf_rdy,
  output logic              accept,
  output logic              app_en,
  output logic [2:0]        app_cmd,
  output logic [ADDR_W-1:0] app_addr,
  output logic [DATA_W-1:0] app_wdf_data,
  output logic              app_wdf_wren,
  output logic              app_wdf_end
);
  assign accept = app_en && app_rdy && (!app_wdf_wren || app_wdf_rdy);
  always_ff @(posedge clk)
    if (rst) begin
      app_en <= 1'b0;
      app_cmd <= CMD_RD;
      app_addr <= '0;
      app_wdf_data <= '0;
      app_wdf_wren <= 1'b0;
      app_wdf_end <= 1'b0;
    end else if (load) begin
      app_en <= 1'b1;
      app_cmd <= ld_cmd;
      app_addr <= ld_addr;
      app_wdf_data <= ld_data;
      app_wdf_wren <= ld_cmd == CMD_WR;
      app_wdf_end <= ld_cmd == CMD_WR;
    end else if (accept) begin
      app_en <= 1'b0;
      app_wdf_wren <= 1'b0;
      app_wdf_end <= 1'b0;
    end
endmodule

// File: rtl/ddr_burst_master.sv
// ddr_burst_master: burst request to per-beat DDR app commands; DDR_BURST_MASTER_STATS_EN adds beat/stall counters
module ddr_burst_master import ddr_pkg::*; #(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int LEN_W = DEF_LEN_W,
  parameter int MAX_OUTSTANDING = DEF_MAX_OUTSTANDING
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_wr,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [LEN_W-1:0]    req_len,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic                wr_valid,
  output logic                wr_ready,
  output logic [DATA_W-1:0]   rd_data,
  output logic                rd_valid,
  output logic                busy,
  output logic                done,
  output logic [ADDR_W-1:0]   app_addr,
  output logic [2:0]          app_cmd,
  output logic                app_en,
  input  logic                app_rdy,
  output logic [DATA_W-1:0]   app_wdf_data,
  output logic [DATA_W/8-1:0] app_wdf_mask,
  output logic                app_wdf_wren,
  output logic                app_wdf_end,
  input  logic                app_wdf_rdy,
  input  logic [DATA_W-1:0]   app_rd_data,
  input  logic                app_rd_data_valid
`ifdef DDR_BURST_MASTER_STATS_EN
  ,
  output logic [31:0]         stat_wr_beats,
  output logic [31:0]         stat_rd_beats,
  output logic [31:0]         stat_stall_cycles
`endif
);
  localparam int CW = $clog2(MAX_OUTSTANDING) + 1;
  state_e state, state_n;
  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0] len_q, issued, acked;
  logic [CW-1:0] outst;
  logic load, acc, acc_rd, ret, last, room, rd_load;
  assign room = !app_en || acc;
  assign acc_rd = acc && !app_wdf_wren;
  assign ret = app_rd_data_valid && (state == RD || state == DRAIN);
  assign last = acked == len_q - LEN_W'(1);
  assign req_ready = state == IDLE;
  assign busy = state != IDLE;
  assign done = state == DONE;
  assign app_wdf_mask = '0;
  assign wr_ready = (state == WR) && (issued != len_q) && room;
  assign rd_load = (state == RD) && (issued != len_q) && room && ((outst + CW'(acc_rd)) < CW'(MAX_OUTSTANDING));
  assign load = (wr_valid && wr_ready) || rd_load;
  ddr_cmd_slot #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_slot (
    .clk(clk),
    .rst(rst),
    .load(load),
    .ld_cmd(state == WR ? CMD_WR : CMD_RD),
    .ld_addr(addr_q),
    .ld_data(wr_data),
    .app_rdy(app_rdy),
    .app_wdf_rdy(app_wdf_rdy),
    .accept(acc),
    .app_en(app_en),
    .app_cmd(app_cmd),
    .app_addr(app_addr),
    .app_wdf_data(app_wdf_data),
    .app_wdf_wren(app_wdf_wren),
    .app_wdf_end(app_wdf_end)
  );
  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (req_valid) state_n = req_len == '0 ? DRAIN : req_wr ? WR : RD;
      WR: if (acc && last) state_n = DONE;
      RD: if (acc && last) state_n = DRAIN;
      DRAIN: if (outst == '0) state_n = DONE;
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      addr_q <= '0;
      len_q <= '0;
      issued <= '0;
      acked <= '0;
      outst <= '0;
      rd_valid <= 1'b0;
      rd_data <= '0;
    end else begin
      state <= state_n;
      if (req_valid && req_ready) begin
        addr_q <= req_addr;
        len_q <= req_len;
        issued <= '0;
        acked <= '0;
      end else begin
        if (load) begin
          addr_q <= addr_q + ADDR_W'(ADDR_STEP);
          issued <= issued + LEN_W'(1);
        end
        if (acc) acked <= acked + LEN_W'(1);
      end
      outst <= outst + CW'(acc_rd) - CW'(ret);
      rd_valid <= ret;
      if (ret) rd_data <= app_rd_data;
    end
`ifdef DDR_BURST_MASTER_STATS_EN
  always_ff @(posedge clk)
    if (rst) begin
      stat_wr_beats <= '0;
      stat_rd_beats <= '0;
      stat_stall_cycles <= '0;
    end else begin
      if (acc && app_wdf_wren && stat_wr_beats != '1) stat_wr_beats <= stat_wr_beats + 32'd1;
      if (acc_rd && stat_rd_beats != '1) stat_rd_beats <= stat_rd_beats + 32'd1;
      if (app_en && !acc && stat_stall_cycles != '1) stat_stall_cycles <= stat_stall_cycles + 32'd1;
    end
`endif
endmodule
